// File: rtl/ram_pkg.sv
// Shared types and constants for the parameterised single-port RAM and its
// clear sequencer.
package ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    function automatic int ram_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: owns the array while zeroing it one word per cycle,
// starting at address 0; a new clear request restarts the sweep.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                end
            end
            CLEAR: begin
                if (clear) begin
                    addr_d = '0;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = CLEAR;
                addr_d  = '0;
            end
        endcase
    end

    assign busy     = (state_q == CLEAR);
    assign clr_addr = addr_q;

endmodule

// File: rtl/param_sp_ram.sv
// Parameterised single-port RAM with selectable read-during-write policy,
// optional output register and a built-in array clear sequencer.
module param_sp_ram
    import ram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 4,
    parameter int RD_MODE = RD_FIRST,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    input  logic              clear,
    output logic [DATA_W-1:0] out,
    output logic              rd_valid,
    output logic              busy
);

    localparam int DEPTH       = ram_depth(ADDR_W);
    localparam bit WRITE_FIRST = (RD_MODE == WR_FIRST);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              seq_busy;
    logic [ADDR_W-1:0] seq_addr;

    ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .busy     (seq_busy),
        .clr_addr (seq_addr)
    );

    // User accesses are locked out while the sequencer owns the array or rst is high.
    logic              acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;

    always_comb begin
        acc       = en & ~seq_busy & ~rst;
        mem_we    = seq_busy | (acc & wr);
        mem_addr  = seq_busy ? seq_addr : address;
        mem_wdata = seq_busy ? '0 : in;
        rd_word   = (WRITE_FIRST && wr) ? in : mem[mem_addr];
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    logic [DATA_W-1:0] data_out;
    logic              vld_out;

    generate
        if (OUT_REG == 0) begin : g_no_oreg
            logic [DATA_W-1:0] data_p0;
            logic              vld_p0;

            // stage p0: array read straight into the output register
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_p0 <= '0;
                    vld_p0  <= 1'b0;
                end else begin
                    vld_p0 <= acc;
                    if (acc) begin
                        data_p0 <= rd_word;
                    end
                end
            end

            assign data_out = data_p0;
            assign vld_out  = vld_p0;
        end else begin : g_oreg
            logic [DATA_W-1:0] data_p0;
            logic              vld_p0;
            logic [DATA_W-1:0] data_p1;
            logic              vld_p1;

            // stage p0: array read register
            always_ff @(posedge clk) begin
                if (acc) begin
                    data_p0 <= rd_word;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p0 <= 1'b0;
                end else begin
                    vld_p0 <= acc;
                end
            end

            // stage p1: extra output register, holds between results
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_p1 <= '0;
                    vld_p1  <= 1'b0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        data_p1 <= data_p0;
                    end
                end
            end

            assign data_out = data_p1;
            assign vld_out  = vld_p1;
        end
    endgenerate

    assign out      = data_out;
    assign rd_valid = vld_out;
    assign busy     = seq_busy;

endmodule

// File: tb/tb_param_sp_ram.sv
// Bench for param_sp_ram: four parameter variants driven in parallel against
// a latency/array model, plus directed literal checks.
module tb_param_sp_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       wr = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] address = 4'd0;
    logic [7:0] din = 8'd0;

    // variant v: bit1 = RD_MODE (write-first), bit0 = OUT_REG
    logic [7:0] dout [4];
    logic       dvld [4];
    logic       dbusy[4];

    always #5 clk = ~clk;

    param_sp_ram #(.DATA_W(8), .ADDR_W(4), .RD_MODE(0), .OUT_REG(0)) u_v0 (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .address(address), .in(din),
        .clear(clear), .out(dout[0]), .rd_valid(dvld[0]), .busy(dbusy[0]));
    param_sp_ram #(.DATA_W(8), .ADDR_W(4), .RD_MODE(0), .OUT_REG(1)) u_v1 (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .address(address), .in(din),
        .clear(clear), .out(dout[1]), .rd_valid(dvld[1]), .busy(dbusy[1]));
    param_sp_ram #(.DATA_W(8), .ADDR_W(4), .RD_MODE(1), .OUT_REG(0)) u_v2 (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .address(address), .in(din),
        .clear(clear), .out(dout[2]), .rd_valid(dvld[2]), .busy(dbusy[2]));
    param_sp_ram #(.DATA_W(8), .ADDR_W(4), .RD_MODE(1), .OUT_REG(1)) u_v3 (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .address(address), .in(din),
        .clear(clear), .out(dout[3]), .rd_valid(dvld[3]), .busy(dbusy[3]));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] mem_m [16];
    int         m_left = 0;
    int         n = 1;
    bit         acc_h [4096];
    logic [7:0] rf_h  [4096];
    logic [7:0] wf_h  [4096];
    logic [7:0] eo [4];
    logic       ev [4];
    logic       eb = 1'b0;
    bit         chk_on = 1'b0;
    bit         m_acc;
    logic [7:0] m_rf, m_wf;

    always @(posedge clk) begin
        m_acc = en && (m_left == 0) && !rst;
        m_rf  = 8'h00;
        m_wf  = 8'h00;
        if (m_acc) begin
            m_rf = mem_m[address];
            m_wf = wr ? din : mem_m[address];
            if (wr) mem_m[address] = din;
        end
        acc_h[n % 4096] = m_acc;
        rf_h[n % 4096]  = m_rf;
        wf_h[n % 4096]  = m_wf;
        // a clear lasts 16 cycles and nothing can observe the array meanwhile
        if (rst || clear) begin
            m_left = 16;
            for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        end else if (m_left > 0) begin
            m_left--;
        end
        for (int v = 0; v < 4; v++) begin
            int k;
            k = n - (v & 1);
            if (rst) begin
                eo[v] = 8'h00;
                ev[v] = 1'b0;
            end else begin
                ev[v] = acc_h[k % 4096];
                if (ev[v]) eo[v] = (v >= 2) ? wf_h[k % 4096] : rf_h[k % 4096];
            end
        end
        eb = (m_left > 0);
        if (rst) chk_on = 1'b1;
        n++;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int v = 0; v < 4; v++) begin
                chk($sformatf("model_busy_v%0d", v), 32'(dbusy[v]), 32'(eb));
                chk($sformatf("model_out_v%0d", v), 32'(dout[v]), 32'(eo[v]));
                chk($sformatf("model_vld_v%0d", v), 32'(dvld[v]), 32'(ev[v]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input logic r, input logic c, input logic e, input logic w,
                       input logic [3:0] a, input logic [7:0] d);
        #1;
        rst = r; clear = c; en = e; wr = w; address = a; din = d;
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input int v, input logic [7:0] eo_l, input logic ev_l);
        chk($sformatf("%s_out_v%0d", nm, v), 32'(dout[v]), 32'(eo_l));
        chk($sformatf("%s_vld_v%0d", nm, v), 32'(dvld[v]), 32'(ev_l));
    endtask

    task automatic count_busy(input logic e, output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!dbusy[0]) break;
            cnt++;
            cyc(1'b0, 1'b0, e, 1'b0, 4'(i), 8'h00);
            for (int v = 0; v < 4; v++)
                chk($sformatf("busy_novld_v%0d", v), 32'(dvld[v]), 32'd0);
        end
    endtask

    initial begin
        int cnt;
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        // reset, then busy for exactly 16 cycles
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 8'hFF);
        for (int v = 0; v < 4; v++) begin
            lit("reset", v, 8'h00, 1'b0);
            chk($sformatf("reset_busy_v%0d", v), 32'(dbusy[v]), 32'd1);
        end
        count_busy(1'b0, cnt);
        chk("reset_busy_cycles", cnt, 16);
        for (int v = 0; v < 4; v++) lit("post_reset", v, 8'h00, 1'b0);

        // write A5 at 3, read 3
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 8'hA5);
        lit("wr3", 0, 8'h00, 1'b1);
        lit("wr3", 2, 8'hA5, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
        lit("rd3", 0, 8'hA5, 1'b1);
        lit("rd3", 1, 8'h00, 1'b1);
        lit("rd3", 3, 8'hA5, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        lit("rd3_l2", 1, 8'hA5, 1'b1);
        lit("rd3_hold", 0, 8'hA5, 1'b0);

        // read-during-write policy
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 8'h11);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 8'h22);
        lit("rdw", 0, 8'h11, 1'b1);
        lit("rdw", 2, 8'h22, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        lit("rdw", 1, 8'h11, 1'b1);
        lit("rdw", 3, 8'h22, 1'b1);

        // fill, clear with a last-cycle read, blocked reads, then read back zeros
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'(i), 8'h40 + 8'(i));
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 8'h00);
        lit("preclear_rd", 0, 8'h49, 1'b1);
        chk("clear_busy_rise", 32'(dbusy[0]), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 8'h00);
        lit("preclear_rd", 1, 8'h49, 1'b1);
        lit("clear_blocked", 0, 8'h49, 1'b0);
        count_busy(1'b1, cnt);
        chk("clear_busy_cycles", cnt, 15);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'(i), 8'h00);
            lit("zero_rd", 0, 8'h00, 1'b1);
            if (i > 0) lit("zero_rd", 1, 8'h00, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        lit("zero_rd_last", 1, 8'h00, 1'b1);

        // restart clear at sequencer address 7
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
        count_busy(1'b0, cnt);
        chk("restart_busy_cycles", cnt, 16);

        // reset during a read burst
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 8'h5A);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 8'hC3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 8'h00);
        lit("burst_rd1", 0, 8'h5A, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 8'h00);
        lit("burst_rd2", 0, 8'hC3, 1'b1);
        lit("burst_rd1", 1, 8'h5A, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 8'h00);
        for (int v = 0; v < 4; v++) begin
            lit("midrst", v, 8'h00, 1'b0);
            chk($sformatf("midrst_busy_v%0d", v), 32'(dbusy[v]), 32'd1);
        end
        count_busy(1'b1, cnt);
        chk("midrst_busy_cycles", cnt, 16);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 8'h00);
        lit("after_rst_rd", 0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
